// File: rtl/mpram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mpram_pkg
// Purpose  : Shared types and helpers for the LVT multi-port register file.
// Revision : 1.0
// ============================================================================
package mpram_pkg;

    typedef enum logic [0:0] {
        MPRAM_CLEAR = 1'b0,
        MPRAM_RUN   = 1'b1
    } mpram_state_e;

    // Width of one LVT entry: enough bits to name any write port, minimum 1.
    function automatic int lvt_sel_width(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mpram_bank.sv
`default_nettype none
// ============================================================================
// Module   : mpram_bank
// Purpose  : NR-read / 1-write distributed RAM bank, async read, no reset.
// Revision : 1.0
// ============================================================================
module mpram_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int NR    = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic [NR*AW-1:0]    raddr_i,
    output logic [NR*WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    for (genvar r = 0; r < NR; r++) begin : g_rd
        assign rdata_o[r*WIDTH +: WIDTH] = mem_q[raddr_i[r*AW +: AW]];
    end

endmodule
`default_nettype wire

// File: rtl/mpram_lvt_nrmw.sv
`default_nettype none
// ============================================================================
// Module   : mpram_lvt_nrmw
// Purpose  : NR-read / NW-write LVT register file with built-in clear
//            sequencer. Optional MPRAM_WRITE_BYPASS_EN forwards same-cycle
//            write data to matching read ports.
// Revision : 1.0
// ============================================================================
module mpram_lvt_nrmw
    import mpram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int NR    = 3,
    parameter int NW    = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int BW   = lvt_sel_width(NW)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    output logic                ready_o,
    input  logic [NR*AW-1:0]    raddr_i,
    output logic [NR*WIDTH-1:0] rdata_o,
    input  logic [NW-1:0]       we_i,
    input  logic [NW*AW-1:0]    waddr_i,
    input  logic [NW*WIDTH-1:0] wdata_i
);

    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    mpram_state_e     state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             clearing;

    logic [NR*WIDTH-1:0] bank_rd [NW];
    logic [WIDTH-1:0]    rd_raw  [NR];

    assign clearing = (state_q == MPRAM_CLEAR);
    assign ready_o  = (state_q == MPRAM_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MPRAM_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = MPRAM_RUN;
                end
            end
            MPRAM_RUN: begin
                cnt_d = '0;
                if (clear_i) begin
                    state_d = MPRAM_CLEAR;
                end
            end
            default: begin
                state_d = MPRAM_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MPRAM_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // While clearing, every bank is hijacked to write zero at the sweep pointer.
    for (genvar w = 0; w < NW; w++) begin : g_bank
        logic             bank_we;
        logic [AW-1:0]    bank_waddr;
        logic [WIDTH-1:0] bank_wdata;

        assign bank_we    = clearing | we_i[w];
        assign bank_waddr = clearing ? cnt_q : waddr_i[w*AW +: AW];
        assign bank_wdata = clearing ? '0    : wdata_i[w*WIDTH +: WIDTH];

        mpram_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .NR    (NR),
            .AW    (AW)
        ) u_bank (
            .clk     (clk),
            .we_i    (bank_we),
            .waddr_i (bank_waddr),
            .wdata_i (bank_wdata),
            .raddr_i (raddr_i),
            .rdata_o (bank_rd[w])
        );
    end

    if (NW > 1) begin : g_lvt
        logic [BW-1:0] lvt_q [DEPTH];
        logic [BW-1:0] lvt_d [DEPTH];

        // Ascending loop: the highest enabled port claims a shared address.
        always_comb begin
            lvt_d = lvt_q;
            if (clearing) begin
                lvt_d[cnt_q] = '0;
            end else begin
                for (int w = 0; w < NW; w++) begin
                    if (we_i[w]) begin
                        lvt_d[waddr_i[w*AW +: AW]] = BW'(w);
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    lvt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    lvt_q[i] <= lvt_d[i];
                end
            end
        end

        always_comb begin
            for (int r = 0; r < NR; r++) begin
                rd_raw[r] = bank_rd[lvt_q[raddr_i[r*AW +: AW]]][r*WIDTH +: WIDTH];
            end
        end
    end else begin : g_no_lvt
        always_comb begin
            for (int r = 0; r < NR; r++) begin
                rd_raw[r] = bank_rd[0][r*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int r = 0; r < NR; r++) begin
            logic [WIDTH-1:0] d;
            d = rd_raw[r];
`ifdef MPRAM_WRITE_BYPASS_EN
            for (int w = 0; w < NW; w++) begin
                if (we_i[w] && (waddr_i[w*AW +: AW] == raddr_i[r*AW +: AW])) begin
                    d = wdata_i[w*WIDTH +: WIDTH];
                end
            end
`endif
            if (clearing) begin
                d = '0;
            end
            rdata_o[r*WIDTH +: WIDTH] = d;
        end
    end

endmodule
`default_nettype wire
